mem_stage: RTL

Memory-access stage of the ARM pipeline, consuming the EXE/MEM pipeline register (ALU result, store data, destination, control bits) and producing the values for the MEM/WB register. It holds a word-addressed data memory behind a fixed-latency access state machine. It drives a `ready` signal that freezes the rest of the pipeline while a load or store is in progress.

---
 rtl/mem_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the ARM pipeline.
// Consumes the EXE/MEM register and produces the MEM/WB values. A word-addressed
// data memory sits behind a fixed-latency IDLE -> BUSY -> DONE access machine.
// While an access is in flight, ready is held low to freeze the upstream pipeline.
module mem_stage #(
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_r_m_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic        ready,
  output logic        addr_err
);

  localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   memData_q, memData_d;
  logic          addrErr_q, addrErr_d;
  logic [31:0]   mem_q [MEM_DEPTH];

  logic          req;
  logic          access;
  logic          doWrite;
  logic          inRange;
  logic [31:0]   offset;
  logic [31:0]   wordOffset;
  logic [AW-1:0] memIndex;

  // Request detection and address decode; the two byte-offset bits are dropped by the shift.
  assign req        = mem_r_en_in | mem_w_en_in;
  assign offset     = alu_res_in - BASE_ADDR;
  assign wordOffset = offset >> 2;
  assign inRange    = (alu_res_in >= BASE_ADDR) && (wordOffset < MEM_DEPTH);
  assign memIndex   = wordOffset[AW-1:0];

  // Pipeline-facing outputs; enables are gated so WB never captures a stalled instruction twice.
  assign ready        = ~req | (state_q == DONE);
  assign wb_en_out    = wb_en_in & ready;
  assign mem_r_en_out = mem_r_en_in & ready;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;
  assign mem_data_out = memData_q;
  assign addr_err     = addrErr_q;

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; access fires on the edge that leaves BUSY with the counter exhausted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          access  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Access outcome: a store wins when both enables are set; out-of-range returns zero and flags an error.
  always_comb begin
    memData_d = memData_q;
    addrErr_d = 1'b0;
    doWrite   = 1'b0;
    if (access) begin
      if (!inRange) begin
        memData_d = 32'd0;
        addrErr_d = 1'b1;
      end else if (mem_w_en_in) begin
        doWrite = 1'b1;
      end else begin
        memData_d = mem_q[memIndex];
      end
    end
  end

  // Load data and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memData_q <= 32'd0;
      addrErr_q <= 1'b0;
    end else begin
      memData_q <= memData_d;
      addrErr_q <= addrErr_d;
    end
  end

  // Data memory array; reset clears every word so an aborted store leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (doWrite) begin
      mem_q[memIndex] <= val_r_m_in;
    end
  end

endmodule
